// File: rtl/mux_n_pipe.sv
// mux_n_pipe: parametrised N:1 selector with a single registered output stage.
// Every input channel and the output use a valid/ready handshake. Mode 0 steers
// by the sel input and flags out-of-range selects on sel_err. Mode 1 arbitrates
// round-robin among the valid channels.
// Optional build macro MUX_N_PIPE_STATS_EN adds two counters:
//   xfer_cnt - wrapping count of accepted transfers
//   err_cnt  - saturating count of sel_err pulses
module mux_n_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IN  = 3,
    parameter int unsigned SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_src,
    output logic                  sel_err
`ifdef MUX_N_PIPE_STATS_EN
    ,
    output logic [15:0]           xfer_cnt,
    output logic [7:0]            err_cnt
`endif
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic             sel_err_q, sel_err_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             can_acc;
    logic             sel_ok;
    logic             grant_vld;
    logic             grant_has_valid;
    logic             xfer;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;

    logic             rr_lo_found, rr_hi_found;
    logic [SEL_W-1:0] rr_lo_grant, rr_hi_grant;
    logic [SEL_W-1:0] rr_grant;

    assign can_acc = !out_valid_q || out_ready;
    assign sel_ok  = 32'(sel) < N_IN;

    // Round-robin search: the lowest valid index at or above rr_ptr wins.
    // If there is none, the search wraps to the lowest valid index overall.
    always_comb begin
        rr_lo_found = 1'b0;
        rr_hi_found = 1'b0;
        rr_lo_grant = '0;
        rr_hi_grant = '0;
        for (int k = 0; k < int'(N_IN); k++) begin
            if (in_valid[k]) begin
                if (!rr_lo_found) begin
                    rr_lo_found = 1'b1;
                    rr_lo_grant = SEL_W'(k);
                end
                if (!rr_hi_found && (32'(k) >= 32'(rr_ptr_q))) begin
                    rr_hi_found = 1'b1;
                    rr_hi_grant = SEL_W'(k);
                end
            end
        end
        rr_grant = rr_hi_found ? rr_hi_grant : rr_lo_grant;
    end

    // Resolve the grant for the active mode and gather the granted channel's data and valid.
    always_comb begin
        grant           = mode ? rr_grant : sel;
        grant_vld       = mode ? rr_lo_found : sel_ok;
        grant_has_valid = 1'b0;
        grant_data      = '0;
        in_ready        = '0;
        for (int k = 0; k < int'(N_IN); k++) begin
            if (SEL_W'(k) == grant) begin
                grant_has_valid = in_valid[k];
                grant_data      = in_data[k*WIDTH +: WIDTH];
                in_ready[k]     = !rst && can_acc && grant_vld;
            end
        end
        xfer = !rst && can_acc && grant_vld && grant_has_valid;
    end

    // Next state of the output stage, the error pulse and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        sel_err_d   = !mode && !sel_ok && can_acc;
        if (xfer) begin
            out_data_d  = grant_data;
            out_src_d   = grant;
            out_valid_d = 1'b1;
            if (mode) begin
                rr_ptr_d = (32'(grant) == N_IN - 1) ? '0 : grant + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage registers; reset drops any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            sel_err_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            sel_err_q   <= sel_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign sel_err   = sel_err_q;

`ifdef MUX_N_PIPE_STATS_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Transfer count wraps naturally. Error count sticks at all-ones.
    always_comb begin
        xfer_cnt_d = xfer ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
        err_cnt_d  = (sel_err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // Statistics counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Testbench for mux_n_pipe (WIDTH=32, N_IN=3, SEL_W=2).
// A behavioural model computes the grant from the selection rules with modular
// arithmetic. Every DUT output is compared against that model once per cycle.
module tb_mux_n_pipe;

    localparam int WIDTH = 32;
    localparam int N_IN  = 3;
    localparam int SEL_W = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_ready;
    logic [SEL_W-1:0]      sel;
    logic                  mode;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [SEL_W-1:0]      out_src;
    logic                  sel_err;
`ifdef MUX_N_PIPE_STATS_EN
    logic [15:0]           xfer_cnt;
    logic [7:0]            err_cnt;
`endif

    mux_n_pipe #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
`ifdef MUX_N_PIPE_STATS_EN
        .xfer_cnt  (xfer_cnt),
        .err_cnt   (err_cnt),
`endif
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [31:0] m_data;
    logic        m_valid;
    int          m_src;
    logic        m_err;
    int          m_rr;
    int          m_xfer_cnt;
    int          m_err_cnt;
    logic [N_IN-1:0] last_in_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N_IN*WIDTH-1:0] rand_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Apply one cycle of stimulus, then check in_ready and the registered outputs against the model.
    task automatic step(input logic r, input logic md, input logic [SEL_W-1:0] s,
                        input logic [N_IN-1:0] iv, input logic [N_IN*WIDTH-1:0] id,
                        input logic ordy);
        int   g;
        logic can;
        logic xf;
        logic [N_IN-1:0] exp_rdy;
        rst       = r;
        mode      = md;
        sel       = s;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        can = !m_valid || ordy;
        g   = -1;
        if (!md) begin
            if (int'(s) < N_IN) g = int'(s);
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                int k;
                k = (m_rr + i) % N_IN;
                if (g < 0 && iv[k]) g = k;
            end
        end
        exp_rdy = (!r && can && g >= 0) ? N_IN'(1 << g) : '0;
        last_in_ready = in_ready;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        xf = !r && can && (g >= 0) && iv[g];
        if (r) begin
            m_data = '0; m_valid = 1'b0; m_src = 0; m_err = 1'b0; m_rr = 0;
            m_xfer_cnt = 0; m_err_cnt = 0;
        end else begin
            m_err = !md && (int'(s) >= N_IN) && can;
            if (m_err && m_err_cnt < 255) m_err_cnt++;
            if (xf) begin
                m_data  = id[g*WIDTH +: WIDTH];
                m_valid = 1'b1;
                m_src   = g;
                if (md) m_rr = (g + 1) % N_IN;
                m_xfer_cnt = (m_xfer_cnt + 1) % 65536;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", out_data, m_data);
        check("out_src", 32'(out_src), 32'(m_src));
        check("sel_err", 32'(sel_err), 32'(m_err));
`ifdef MUX_N_PIPE_STATS_EN
        check("xfer_cnt", 32'(xfer_cnt), 32'(m_xfer_cnt));
        check("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
`endif
    endtask

    initial begin
        int exp_rr [6] = '{0, 1, 2, 0, 1, 2};
        logic [N_IN*WIDTH-1:0] d;
        m_data = '0; m_valid = 1'b0; m_src = 0; m_err = 1'b0; m_rr = 0;
        m_xfer_cnt = 0; m_err_cnt = 0;
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        step(1'b1, 1'b0, 2'd0, 3'b111, rand_data(), 1'b1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);

        // Select-directed single transfer
        d = rand_data();
        d[1*WIDTH +: WIDTH] = 32'hDEADBEEF;
        step(1'b0, 1'b0, 2'd1, 3'b010, d, 1'b1);
        check("tp1_ready", 32'(last_in_ready), 32'(3'b010));
        check("tp1_data", out_data, 32'hDEADBEEF);
        check("tp1_src", 32'(out_src), 32'd1);
        check("tp1_valid", 32'(out_valid), 32'd1);

        // Out-of-range select: one-cycle sel_err, no transfer
        step(1'b0, 1'b0, 2'd3, 3'b111, rand_data(), 1'b1);
        check("bad_sel_ready", 32'(last_in_ready), 32'd0);
        check("bad_sel_err", 32'(sel_err), 32'd1);
        check("bad_sel_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, 2'd0, 3'b000, rand_data(), 1'b1);
        check("bad_sel_pulse_end", 32'(sel_err), 32'd0);

        // Round-robin from a fresh pointer
        step(1'b1, 1'b1, 2'd0, 3'b000, rand_data(), 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 2'd3, 3'b111, rand_data(), 1'b1);
            check("rr_order", 32'(out_src), 32'(exp_rr[i]));
        end

        // Backpressure holds the word; release accepts the next one on the same edge
        d = rand_data();
        d[0 +: WIDTH] = 32'h11;
        step(1'b0, 1'b0, 2'd0, 3'b001, d, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'd1, 3'b111, rand_data(), 1'b0);
            check("stall_hold", out_data, 32'h11);
            check("stall_ready", 32'(last_in_ready), 32'd0);
        end
        d = rand_data();
        d[1*WIDTH +: WIDTH] = 32'h22;
        step(1'b0, 1'b0, 2'd1, 3'b111, d, 1'b1);
        check("release_data", out_data, 32'h22);
        check("release_valid", 32'(out_valid), 32'd1);

        // Reset in the middle of a stall
        step(1'b0, 1'b0, 2'd0, 3'b001, rand_data(), 1'b0);
        step(1'b1, 1'b1, 2'd0, 3'b111, rand_data(), 1'b0);
        check("rst_stall_valid", 32'(out_valid), 32'd0);
        check("rst_stall_data", out_data, 32'd0);
        check("rst_stall_src", 32'(out_src), 32'd0);
        step(1'b0, 1'b1, 2'd0, 3'b111, rand_data(), 1'b1);
        check("rst_rr_ptr", 32'(out_src), 32'd0);

        // Randomised traffic, including mode switches and occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom),
                 3'($urandom), rand_data(), ($urandom_range(0, 3) != 0));
        end

`ifdef MUX_N_PIPE_STATS_EN
        step(1'b1, 1'b1, 2'd0, 3'b000, rand_data(), 1'b1);
        for (int i = 0; i < 70000; i++) begin
            step(1'b0, 1'b1, 2'd0, 3'b111, rand_data(), 1'b1);
        end
        check("xfer_cnt_wrap", 32'(xfer_cnt), 32'd4464);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b0, 2'd3, 3'b111, rand_data(), 1'b1);
        end
        check("err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N:1 data selector with one registered output stage and a valid/ready handshake on every input channel and on the output.
- Successor to the combinational 3:1 32-bit selector used in the single-cycle datapath. It adds a configurable width and input count, a round-robin arbitration mode, backpressure, and out-of-range select reporting.
- Sits between multi-source producers (ALU result, memory read, PC+4, immediate) and a pipelined consumer stage.

Parameters:
- WIDTH, 32, data width per channel.
- N_IN, 3, number of input channels; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N_IN*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  N_IN  per-channel valid.
- in_ready  output  N_IN  per-channel ready; combinational.
- sel  input  SEL_W  channel select, used in mode 0.
- mode  input  1  0 = select-directed, 1 = round-robin.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_src  output  SEL_W  index of the channel that produced out_data.
- sel_err  output  1  registered one-cycle flag for an out-of-range select.

Behaviour:
- Clock and reset: single clock domain. Synchronous active-high reset; the reset level is sampled on the rising edge of clk.
- Reset values: out_data=0, out_valid=0, out_src=0, sel_err=0, round-robin pointer rr_ptr=0.
- Stage-accept condition: can_acc = !out_valid || out_ready.
- Grant, mode 0:
  - grant = sel when sel < N_IN; otherwise no grant.
  - in_ready[k] = can_acc && (k == sel) && (sel < N_IN).
- Grant, mode 1:
  - grant = first k with in_valid[k]=1, searching from rr_ptr upward and wrapping modulo N_IN.
  - in_ready[k] = can_acc && (k == grant).
  - With no valid inputs, no grant.
- Transfer in: occurs when can_acc, a grant exists and in_valid[grant]=1. Next edge:
  - out_data <= channel data
  - out_valid <= 1
  - out_src <= grant
- Round-robin pointer: only on a mode-1 transfer, rr_ptr <= grant+1, wrapping to 0 at N_IN.
- Idle output stage: out_valid drops to 0 when out_ready=1 and no transfer in occurs. While stalled (out_valid=1, out_ready=0), out_data and out_src hold.
- Latency and throughput: 1 cycle input to output; one transfer per cycle when out_ready is held at 1.
- sel_err:
  - Set to 1 on the next edge when mode=0, sel >= N_IN and can_acc=1; otherwise 0. It is a one-cycle pulse per offending cycle.
  - No data moves and all in_ready stay 0 during that cycle.
  - Never asserted in mode 1.
- Mode change: may occur on any cycle and takes effect in the same cycle. rr_ptr is retained across mode switches.
- Reset mid-operation: a held output word is discarded and out_valid=0 on the next edge. Input handshakes sampled in that reset cycle are not accepted, and in_ready is forced to 0 while rst=1.
- Simultaneous output drain and new transfer: the new word replaces the old one on the same edge, with out_valid staying 1.

Optional Feature:
- Macro: MUX_N_PIPE_STATS_EN.
- Defined:
  - Adds output port xfer_cnt (16 bits).
  - Counts transfers into the output stage; reset to 0; wraps from 16'hFFFF to 0.
  - Also adds output port err_cnt (8 bits), counting sel_err assertions and saturating at 8'hFF.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset release, mode 0, sel=1, in_valid=3'b010, channel 1 data 32'hDEADBEEF, out_ready=1 -> one cycle later out_data=32'hDEADBEEF, out_valid=1, out_src=1; in_ready=3'b010.
- Mode 0, sel=3 with N_IN=3, all in_valid=1 -> in_ready=0, next cycle sel_err=1 for exactly one cycle, out_valid=0.
- Mode 1, all in_valid=1, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,0,1,2; rr_ptr wraps to 0.
- Backpressure: word 32'h11 captured, then out_ready=0 for 3 cycles -> out_data holds 32'h11, all in_ready=0; out_ready=1 -> next word accepted on the same edge.
- Reset mid-stall: out_valid=1 with out_ready=0, rst=1 for 1 cycle -> out_valid=0, out_data=0, out_src=0, rr_ptr=0 after the edge.
- With MUX_N_PIPE_STATS_EN: 70000 back-to-back transfers -> xfer_cnt=70000 mod 65536=4464; 300 bad-select cycles -> err_cnt=255.
